// File: rtl/data_buffer_pkg.sv
// Shared constants and types for the data_buffer byte FIFO.
// Imported by data_buffer and fifo_mem.
package data_buffer_pkg;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 64;
  localparam int PTR_W     = 6;
  localparam int OCC_W     = 7;

  typedef logic [DATA_W-1:0] byte_t;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for data_buffer: one write port, one async read.
// Ports: clk, we, waddr, wdata, raddr, rdata. Storage is not reset.
module fifo_mem
  import data_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int WIDTH = DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read is combinational so a pop and a push to the same slot
  // (full buffer) still returns the old head byte.
  assign rdata = mem[raddr];

endmodule

// File: rtl/data_buffer.sv
// Shared RX/TX byte FIFO for the USB endpoint, DEPTH x WIDTH circular.
// Ports: clk, rst (sync, active-high); RX/TX store and get strobes with
// data; Clear, Flush; Buffer_Occupancy. Macro DATA_BUFFER_ASSERT_EN
// compiles runtime checks; functional behaviour is identical either way.
module data_buffer
  import data_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int WIDTH = DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Store_RX_Packet_Data,
  input  logic [WIDTH-1:0]       RX_Packet_Data,
  input  logic                   Get_RX_Data,
  output logic [WIDTH-1:0]       RX_Data,
  input  logic                   Store_TX_Data,
  input  logic [WIDTH-1:0]       TX_Data,
  input  logic                   Get_TX_Packet_Data,
  output logic [WIDTH-1:0]       TX_Packet_Data,
  input  logic                   Clear,
  input  logic                   Flush,
  output logic [$clog2(DEPTH):0] Buffer_Occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] tx_q;

  logic             push_req;
  logic             pop_req;
  logic             push_ok;
  logic             pop_ok;
  logic             mem_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  assign push_req = Store_RX_Packet_Data | Store_TX_Data;
  assign pop_req  = Get_RX_Data | Get_TX_Packet_Data;

  assign wdata = Store_RX_Packet_Data ? RX_Packet_Data : TX_Data;

  // A pop from a full buffer frees the slot the push lands in.
  assign pop_ok  = pop_req & (count_q != '0);
  assign push_ok = push_req & ((count_q != FULL) | pop_ok);

  assign mem_we = push_ok & ~rst & ~Flush & ~Clear;

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
    end else if (Flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
    end else if (Clear) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
        if (Get_RX_Data) rx_q <= rdata;
        else             tx_q <= rdata;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign RX_Data          = rx_q;
  assign TX_Packet_Data   = tx_q;
  assign Buffer_Occupancy = count_q;

`ifdef DATA_BUFFER_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      a_count_max : assert (count_q <= FULL)
        else $error("data_buffer: count %0d above depth", count_q);
      w_push_full : assert (!(push_req && count_q == FULL && !pop_req))
        else $warning("data_buffer: push while full dropped");
      w_pop_empty : assert (!(pop_req && count_q == '0))
        else $warning("data_buffer: pop while empty ignored");
      w_dual_store : assert (!(Store_RX_Packet_Data && Store_TX_Data))
        else $warning("data_buffer: RX and TX store together");
    end
  end
`else
  // No runtime checks in this build.
`endif

endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_data_buffer;
  import data_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst, srx, grx, stx, gtx, clr, fl;
  byte_t      rxd, txd, rx_out, tx_out;
  logic [6:0] occ;

  int total = 0;
  int bad   = 0;

  byte_t q[$];
  byte_t m_rx, m_tx;

  always #5 clk = ~clk;

  data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .Store_RX_Packet_Data (srx),
    .RX_Packet_Data       (rxd),
    .Get_RX_Data          (grx),
    .RX_Data              (rx_out),
    .Store_TX_Data        (stx),
    .TX_Data              (txd),
    .Get_TX_Packet_Data   (gtx),
    .TX_Packet_Data       (tx_out),
    .Clear                (clr),
    .Flush                (fl),
    .Buffer_Occupancy     (occ)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set(input logic r, input logic s_rx, input byte_t d_rx,
                     input logic g_rx, input logic s_tx, input byte_t d_tx,
                     input logic g_tx, input logic c, input logic f);
    rst = r; srx = s_rx; rxd = d_rx; grx = g_rx;
    stx = s_tx; txd = d_tx; gtx = g_tx; clr = c; fl = f;
  endtask

  task automatic idle();
    set(0, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0);
  endtask

  // Reference: FIFO as a queue, rules applied in priority order.
  task automatic model();
    byte_t h;
    if (rst || fl) begin
      q.delete();
      m_rx = '0;
      m_tx = '0;
    end else if (clr) begin
      q.delete();
    end else begin
      if ((grx || gtx) && q.size() > 0) begin
        h = q.pop_front();
        if (grx) m_rx = h;
        else     m_tx = h;
      end
      if ((srx || stx) && q.size() < 64)
        q.push_back(srx ? rxd : txd);
    end
  endtask

  task automatic tick(input string nm);
    @(posedge clk);
    model();
    #1;
    chk({nm, "_occ"}, {1'b0, occ}, 8'(q.size()));
    chk({nm, "_rx"}, rx_out, m_rx);
    chk({nm, "_tx"}, tx_out, m_tx);
    idle();
  endtask

  task automatic push_tx(input byte_t d);
    set(0, 0, 8'd0, 0, 1, d, 0, 0, 0);
    tick("push");
  endtask

  task automatic pop_tx();
    set(0, 0, 8'd0, 0, 0, 8'd0, 1, 0, 0);
    tick("pop");
  endtask

  task automatic do_reset();
    set(1, 0, 8'd0, 0, 0, 8'd0, 0, 0, 0);
    tick("rst");
  endtask

  typedef struct {
    logic       s_rx;
    byte_t      d_rx;
    logic       g_rx;
    logic [6:0] e_occ;
    byte_t      e_rx;
  } vec_t;

  vec_t tbl[9];

  initial begin
    byte_t pat[3];
    pat[0] = 8'd77; pat[1] = 8'd88; pat[2] = 8'd99;

    tbl[0] = '{1, 8'd44, 0, 7'd1, 8'd0};
    tbl[1] = '{1, 8'd77, 0, 7'd2, 8'd0};
    tbl[2] = '{1, 8'd88, 0, 7'd3, 8'd0};
    tbl[3] = '{1, 8'd99, 0, 7'd4, 8'd0};
    tbl[4] = '{0, 8'd0,  1, 7'd3, 8'd44};
    tbl[5] = '{0, 8'd0,  1, 7'd2, 8'd77};
    tbl[6] = '{0, 8'd0,  1, 7'd1, 8'd88};
    tbl[7] = '{0, 8'd0,  1, 7'd0, 8'd99};
    tbl[8] = '{0, 8'd0,  1, 7'd0, 8'd99};

    idle();
    m_rx = '0;
    m_tx = '0;
    do_reset();
    chk("reset_occ", {1'b0, occ}, 8'd0);
    chk("reset_rx", rx_out, 8'd0);
    chk("reset_tx", tx_out, 8'd0);

    // Empty pop after reset
    set(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
    tick("epop");
    chk("epop_rx", rx_out, 8'd0);
    chk("epop_occ", {1'b0, occ}, 8'd0);

    // RX small via vector table
    for (int i = 0; i < 9; i++) begin
      set(0, tbl[i].s_rx, tbl[i].d_rx, tbl[i].g_rx, 0, 8'd0, 0, 0, 0);
      tick("vec");
      chk($sformatf("vec%0d_occ", i), {1'b0, occ}, {1'b0, tbl[i].e_occ});
      chk($sformatf("vec%0d_rx", i), rx_out, tbl[i].e_rx);
    end

    // TX overflow: 92 held stores, first 64 kept
    for (int i = 0; i < 92; i++) begin
      set(0, 0, 8'd0, 0, 1, (i == 0) ? 8'd88 : pat[(i-1)%3], 0, 0, 0);
      tick("ovf_push");
    end
    chk("ovf_occ", {1'b0, occ}, 8'd64);
    for (int i = 0; i < 64; i++) begin
      pop_tx();
      chk($sformatf("ovf_pop%0d", i), tx_out,
          (i == 0) ? 8'd88 : pat[(i-1)%3]);
      tick("ovf_gap");
    end
    chk("ovf_empty", {1'b0, occ}, 8'd0);
    for (int i = 0; i < 3; i++) pop_tx();
    chk("ovf_hold", tx_out, pat[62%3]);

    // Clear
    for (int i = 0; i < 64; i++) push_tx(byte_t'(i + 1));
    chk("clr_full", {1'b0, occ}, 8'd64);
    for (int i = 0; i < 9; i++) pop_tx();
    set(0, 0, 8'd0, 0, 1, 8'd5, 1, 1, 0);
    tick("clr");
    chk("clr_occ", {1'b0, occ}, 8'd0);
    chk("clr_tx", tx_out, 8'd9);
    push_tx(8'd77); push_tx(8'd88); push_tx(8'd99);
    pop_tx();
    chk("clr_pop1", tx_out, 8'd77);
    pop_tx();
    chk("clr_pop2", tx_out, 8'd88);
    chk("clr_occ1", {1'b0, occ}, 8'd1);

    // Flush
    for (int i = 0; i < 64; i++) push_tx(byte_t'(100 + i));
    chk("fl_full", {1'b0, occ}, 8'd64);
    for (int i = 0; i < 22; i++) pop_tx();
    set(0, 0, 8'd0, 1, 0, 8'd0, 0, 0, 0);
    tick("fl_rxpop");
    set(0, 0, 8'd0, 0, 0, 8'd0, 0, 1, 1);
    tick("fl");
    chk("fl_occ", {1'b0, occ}, 8'd0);
    chk("fl_tx", tx_out, 8'd0);
    chk("fl_rx", rx_out, 8'd0);

    // Simultaneous push and pop
    do_reset();
    for (int i = 0; i < 5; i++) push_tx(byte_t'(10 + i));
    set(0, 0, 8'd0, 0, 1, 8'd50, 1, 0, 0);
    tick("sim5");
    chk("sim5_occ", {1'b0, occ}, 8'd5);
    chk("sim5_tx", tx_out, 8'd10);
    for (int i = 0; i < 64; i++) push_tx(byte_t'(200 + i));
    chk("sim64_full", {1'b0, occ}, 8'd64);
    set(0, 0, 8'd0, 0, 1, 8'd51, 1, 0, 0);
    tick("sim64");
    chk("sim64_occ", {1'b0, occ}, 8'd64);
    chk("sim64_tx", tx_out, 8'd11);
    for (int i = 0; i < 64; i++) pop_tx();
    chk("sim64_tail", tx_out, 8'd51);

    // Both stores high: RX byte wins; reset mid-stream
    set(0, 1, 8'd33, 0, 1, 8'd66, 0, 0, 0);
    tick("dual");
    set(0, 0, 8'd0, 1, 0, 8'd0, 1, 0, 0);
    tick("dual_pop");
    chk("dual_rx", rx_out, 8'd33);
    push_tx(8'd1); push_tx(8'd2);
    set(1, 1, 8'd7, 1, 0, 8'd0, 0, 0, 0);
    tick("midrst");
    chk("midrst_occ", {1'b0, occ}, 8'd0);
    chk("midrst_rx", rx_out, 8'd0);

    // Random traffic, phased push/pop bias to reach full and empty
    for (int i = 0; i < 4000; i++) begin
      int pb;
      pb = ((i / 250) % 2 == 0) ? 75 : 25;
      set($urandom_range(0, 499) == 0,
          $urandom_range(0, 99) < pb / 2, byte_t'($urandom),
          $urandom_range(0, 99) < (100 - pb) / 2,
          $urandom_range(0, 99) < pb / 2, byte_t'($urandom),
          $urandom_range(0, 99) < (100 - pb) / 2,
          $urandom_range(0, 199) == 0,
          $urandom_range(0, 299) == 0);
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
